regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with scoreboard for the pipelined RISC-V core.
//  - Generalises the single-write/3-read file: NUM_RD read ports, NUM_WR write ports.
//  - Adds optional same-cycle write-to-read bypass, per-register busy bits and a write-collision flag.
//  - Sits between decode (reads, reservations) and writeback (writes).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  NUM_RD    3   number of read ports
//  NUM_WR    2   number of write ports
//  BYPASS    1   1: read returns same-cycle write data; 0: read returns stored value
//  ZERO_REG  1   1: register 0 hard-wired to zero, never written or reserved
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               reset, asynchronous, active-low
//  we         in   NUM_WR          per-port write enable
//  waddr      in   NUM_WR*ADDR_W   write addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  wdata      in   NUM_WR*DATA_W   write data; same packing as waddr
//  raddr      in   NUM_RD*ADDR_W   read addresses, packed
//  rdata      out  NUM_RD*DATA_W   read data, packed
//  rbusy      out  NUM_RD          busy bit of each read address after same-cycle clears
//  rsv_en     in   1               reserve destination register (decode issue)
//  rsv_addr   in   ADDR_W          register to mark busy
//  wr_clash   out  1               registered: two write ports hit the same register last cycle
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): all registers = 0, all busy bits = 0, wr_clash = 0.
//   - Reset mid-operation discards pending writes and reservations immediately.
//  Write path
//   - Writes commit on posedge clk for every port with we[i]=1.
//   - With ZERO_REG=1, a write to address 0 is ignored.
//   - Two or more enabled ports to the same address: highest-index port wins.
//   - That same edge sets wr_clash=1 for exactly one cycle. Address-0 collisions set wr_clash only when ZERO_REG=0.
//  Read path
//   - Combinational, zero latency.
//   - BYPASS=1: if any enabled write port targets raddr this cycle, rdata = that port's wdata (highest index wins).
//     Otherwise rdata = stored value.
//   - BYPASS=0: always the stored value.
//   - ZERO_REG=1: address 0 reads 0 regardless of writes.
//  Scoreboard
//   - rsv_en=1 sets busy[rsv_addr] on posedge. Ignored for address 0 when ZERO_REG=1.
//   - Any committed write clears busy[waddr] on posedge.
//   - Same-edge reserve and write to the same address: reserve wins (busy stays 1, newer producer).
//   - rbusy[j] = busy[raddr_j] AND NOT (BYPASS=1 and an enabled write targets raddr_j this cycle).
//   - Reserving an already-busy register keeps it busy; no error is raised.
//  Widths: no arithmetic; all data is passed through unmodified at DATA_W.
// TESTING
//  1. Reset: rst_n low async mid-cycle -> all rdata=0, rbusy=0, wr_clash=0 before the next clock edge.
//  2. Bypass: we=01, waddr0=5, wdata0=0xDEADBEEF, raddr0=5 same cycle
//     -> rdata0=0xDEADBEEF (BYPASS=1) or 0 (BYPASS=0); next cycle reads 0xDEADBEEF either way.
//  3. Collision: both ports write reg 7 (0x11 on port 0, 0x22 on port 1)
//     -> reg7=0x22; wr_clash=1 for one cycle, then 0.
//  4. Zero register: write 0x1234 to addr 0 with rsv_en on addr 0 -> rdata=0, rbusy=0 (ZERO_REG=1).
//  5. Scoreboard: reserve reg 3 -> rbusy=1 next cycle.
//     Write reg 3 -> rbusy=0 in the same cycle (bypass) and after the edge.
//     Same-edge reserve and write on reg 3 -> busy stays 1.
//  6. Sweep NUM_RD=4, NUM_WR=1, ADDR_W=4: random writes/reads over 1000 cycles vs reference model -> no mismatch.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard, optional
// same-cycle write-to-read bypass and a registered write-collision flag.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     wr_clash
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic              wr_clash_q, wr_clash_d;
  logic [NUM_WR-1:0] wr_ok;
  logic              rsv_ok;

  // A write or reservation to the hard-wired zero register has no effect at all.
  always_comb begin
    wr_ok = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      wr_ok[i] = we[i] && !(ZERO_REG && (waddr[i*ADDR_W +: ADDR_W] == '0));
    end
    rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == '0));
  end

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    wr_clash_d = 1'b0;
    // Ascending port order lets the highest-index port win on collisions.
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (wr_ok[i]) begin
        regs_d[waddr[i*ADDR_W +: ADDR_W]] = wdata[i*DATA_W +: DATA_W];
        busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (wr_ok[i] && wr_ok[j] &&
            (waddr[i*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W])) begin
          wr_clash_d = 1'b1;
        end
      end
    end
    // Reserve after write: the newer producer keeps the register busy.
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        regs_q[k] <= '0;
      end
      busy_q     <= '0;
      wr_clash_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      wr_clash_q <= wr_clash_d;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              hit;
      ra  = raddr[j*ADDR_W +: ADDR_W];
      d   = regs_q[ra];
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (BYPASS && wr_ok[i] && (waddr[i*ADDR_W +: ADDR_W] == ra)) begin
          d   = wdata[i*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      end
      if (ZERO_REG && (ra == '0)) begin
        d = '0;
      end
      rdata[j*DATA_W +: DATA_W] = d;
      rbusy[j]                  = busy_q[ra] & ~hit;
    end
  end

  assign wr_clash = wr_clash_q;

endmodule
